// File: rtl/ramp_sequencer_pkg.sv
// ramp_seq_pkg: state encoding and default widths shared by the ramp sequencer files
package ramp_seq_pkg;
   localparam int WIDTH_D = 8;
   localparam int DWELL_W_D = 8;
   localparam int CYC_W_D = 4;
   typedef enum logic [2:0] {IDLE, CLEAR, UP, DWELL_HI, DOWN, DWELL_LO, DONE} state_t;
endpackage

// File: rtl/ramp_sequencer_if.sv
// ramp_sequencer_if: control, configuration and counter-side signals of the ramp sequencer
interface ramp_sequencer_if #(
   parameter int WIDTH = ramp_seq_pkg::WIDTH_D,
   parameter int DWELL_W = ramp_seq_pkg::DWELL_W_D,
   parameter int CYC_W = ramp_seq_pkg::CYC_W_D
);
   logic start;
   logic abort;
   logic [WIDTH-1:0] peak;
   logic [WIDTH-1:0] floor;
   logic [DWELL_W-1:0] dwell;
   logic [CYC_W-1:0] cycles;
   logic [WIDTH-1:0] counter_in;
   logic counter_rst;
   logic counter_en;
   logic counter_dir;
   logic busy;
   logic done;
   logic err;
   modport master (
      output start, abort, peak, floor, dwell, cycles, counter_in,
      input counter_rst, counter_en, counter_dir, busy, done, err
   );
   modport slave (
      input start, abort, peak, floor, dwell, cycles, counter_in,
      output counter_rst, counter_en, counter_dir, busy, done, err
   );
endinterface

// File: rtl/ramp_sequencer_dwell_timer.sv
// dwell_timer: loadable down-counter flagging the final cycle of a dwell (0 behaves as 1)
module dwell_timer #(
   parameter int W = 8
) (
   input logic clk,
   input logic rst,
   input logic load,
   input logic [W-1:0] value,
   output logic expire
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= load ? value : cnt - W'(cnt != '0);
   assign expire = cnt[W-1:1] == '0;
endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: drives an up/down counter through a programmed triangular ramp profile
module ramp_sequencer
   import ramp_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int DWELL_W = DWELL_W_D,
   parameter int CYC_W = CYC_W_D
) (
   input logic clk,
   input logic rst,
   ramp_sequencer_if.slave bus
);
   state_t state, nxt;
   logic [WIDTH-1:0] peak_l, floor_l;
   logic [DWELL_W-1:0] dwell_l;
   logic [CYC_W-1:0] left;
   logic at_peak, at_floor, last, bad, accept, load, expire;
   assign at_peak = bus.counter_in == peak_l;
   assign at_floor = bus.counter_in == floor_l;
   assign last = left <= CYC_W'(1);
   assign bad = floor_l > peak_l;
   assign accept = state == IDLE && bus.start && !bus.abort;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         peak_l <= '0;
         floor_l <= '0;
         dwell_l <= '0;
         left <= '0;
      end else if (accept) begin
         peak_l <= bus.peak;
         floor_l <= bus.floor;
         dwell_l <= bus.dwell;
         left <= bus.cycles == '0 ? CYC_W'(1) : bus.cycles;
      end else if (state == DOWN && at_floor && !bus.abort) left <= left - 1'b1;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = bus.start ? CLEAR : IDLE;
         CLEAR: nxt = bad ? DONE : UP;
         UP: nxt = at_peak ? DWELL_HI : UP;
         DWELL_HI: nxt = expire ? DOWN : DWELL_HI;
         DOWN: nxt = at_floor ? (last ? DONE : DWELL_LO) : DOWN;
         DWELL_LO: nxt = expire ? UP : DWELL_LO;
         default: nxt = IDLE;
      endcase
      if (bus.abort) nxt = IDLE;
   end
   // one timer serves both turning points; it is reloaded on the entering edge
   assign load = (nxt == DWELL_HI && state != DWELL_HI) || (nxt == DWELL_LO && state != DWELL_LO);
   dwell_timer #(.W(DWELL_W)) u_timer (
      .clk(clk),
      .rst(rst),
      .load(load),
      .value(dwell_l),
      .expire(expire)
   );
   assign bus.counter_rst = state == CLEAR;
   assign bus.counter_en = !bus.abort && ((state == UP && !at_peak) || (state == DOWN && !at_floor));
   assign bus.counter_dir = state inside {CLEAR, UP, DWELL_HI};
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.err = state == DONE && bad;
endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: ramp sequencer closed around an 8-bit up/down counter
module tb_ramp_sequencer;
   typedef struct packed {
      logic r, e, d, b, dn, er;
      logic [7:0] c;
   } exp_t;
   logic clk = 0;
   logic rst = 1;
   logic [7:0] cnt = 0;
   logic [7:0] nc;
   int n_cmp = 0;
   int n_bad = 0;
   exp_t cur = '0;
   exp_t want;
   exp_t q[$];
   int rv[64];
   logic rd[64], rer[64], ren[64], rb[64];
   ramp_sequencer_if bus();
   ramp_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.counter_in = cnt;
   always @(posedge clk)
      if (bus.counter_rst) cnt <= 8'd0;
      else if (bus.counter_en) cnt <= bus.counter_dir ? cnt + 8'd1 : cnt - 8'd1;
   function automatic exp_t ent(logic r, logic e, logic d, logic b, logic dn, logic er, logic [7:0] c);
      exp_t x;
      x = '{r, e, d, b, dn, er, c};
      return x;
   endfunction
   // expected per-cycle trace of a whole profile, from CLEAR through DONE
   function automatic void build(int p, int f, int d, int c, logic [7:0] c0);
      int n = c == 0 ? 1 : c;
      int dw = d == 0 ? 1 : d;
      q.push_back(ent(1, 0, 1, 1, 0, 0, c0));
      if (f > p) begin
         q.push_back(ent(0, 0, 0, 1, 1, 1, 8'd0));
         return;
      end
      for (int i = 0; i < n; i++) begin
         for (int v = (i == 0 ? 0 : f); v <= p; v++) q.push_back(ent(0, v != p, 1, 1, 0, 0, 8'(v)));
         repeat (dw) q.push_back(ent(0, 0, 1, 1, 0, 0, 8'(p)));
         for (int v = p; v >= f; v--) q.push_back(ent(0, v != f, 0, 1, 0, 0, 8'(v)));
         if (i == n - 1) q.push_back(ent(0, 0, 0, 1, 1, 0, 8'(f)));
         else repeat (dw) q.push_back(ent(0, 0, 0, 1, 0, 0, 8'(f)));
      end
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         cur = ent(0, 0, 0, 0, 0, 0, cur.c);
      end else begin
         nc = cur.r ? 8'd0 : (cur.e && !(bus.abort && cur.b)) ? (cur.d ? cur.c + 8'd1 : cur.c - 8'd1) : cur.c;
         if (cur.b && bus.abort) q.delete();
         else if (!cur.b && bus.start && !bus.abort)
            build(int'(bus.peak), int'(bus.floor), int'(bus.dwell), int'(bus.cycles), nc);
         cur = q.size() != 0 ? q.pop_front() : ent(0, 0, 0, 0, 0, 0, nc);
      end
   end
   always @(negedge clk) begin
      want = cur;
      want.e = cur.e & ~(bus.abort & cur.b);
      n_cmp++;
      if ({bus.counter_rst, bus.counter_en, bus.counter_dir, bus.busy, bus.done, bus.err, cnt} !== want) begin
         n_bad++;
         $display("FAIL cycle @%0t: got rst/en/dir/busy/done/err=%b%b%b%b%b%b cnt=%0d, want %b%b%b%b%b%b cnt=%0d",
            $time, bus.counter_rst, bus.counter_en, bus.counter_dir, bus.busy, bus.done, bus.err, cnt,
            want.r, want.e, want.d, want.b, want.dn, want.er, want.c);
      end
   end
   task automatic tick;
      @(negedge clk);
      #1;
   endtask
   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask
   task automatic go(int p, int f, int d, int c);
      tick;
      bus.peak = 8'(p);
      bus.floor = 8'(f);
      bus.dwell = 8'(d);
      bus.cycles = 4'(c);
      bus.abort = 0;
      bus.start = 1;
      tick;
      bus.start = 0;
   endtask
   task automatic record(int n);
      for (int i = 0; i < n; i++) begin
         rv[i] = int'(cnt);
         rd[i] = bus.done;
         rer[i] = bus.err;
         ren[i] = bus.counter_en;
         rb[i] = bus.busy;
         tick;
      end
   endtask
   function automatic int first_done(int n);
      for (int i = 0; i < n; i++) if (rd[i]) return i;
      return -1;
   endfunction
   task automatic wait_idle;
      int k = 0;
      while (bus.busy && k < 2000) begin
         tick;
         k++;
      end
      if (bus.busy) chk("idle_timeout", 1, 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int exp1[15] = '{0, 0, 1, 2, 3, 4, 5, 5, 5, 5, 5, 4, 3, 2, 2};
      int mx, mn, en_any;
      bus.start = 0;
      bus.abort = 0;
      bus.peak = 0;
      bus.floor = 0;
      bus.dwell = 0;
      bus.cycles = 0;
      repeat (3) tick;
      chk("reset_outs", int'({bus.counter_rst, bus.counter_en, bus.counter_dir, bus.busy, bus.done, bus.err}), 0);
      rst = 0;
      tick;
      go(5, 2, 3, 1);
      record(16);
      for (int i = 0; i < 15; i++) chk($sformatf("t1_cnt%0d", i), rv[i], exp1[i]);
      chk("t1_done_at", first_done(16), 14);
      chk("t1_err", int'(rer[14]), 0);
      chk("t1_busy_after", int'(rb[15]), 0);
      go(3, 1, 0, 2);
      record(20);
      chk("t2_done_at", first_done(20), 17);
      mx = 0;
      mn = 255;
      for (int i = 1; i <= 17; i++) mx = rv[i] > mx ? rv[i] : mx;
      for (int i = 4; i <= 17; i++) mn = rv[i] < mn ? rv[i] : mn;
      chk("t2_max", mx, 3);
      chk("t2_min", mn, 1);
      go(4, 7, 2, 1);
      record(4);
      en_any = 0;
      for (int i = 0; i < 4; i++) en_any |= int'(ren[i]);
      chk("t3_done_at", first_done(4), 1);
      chk("t3_err", int'(rer[1]), 1);
      chk("t3_en", en_any, 0);
      go(10, 0, 1, 1);
      for (int k = 0; k < 50 && cnt != 8'd3; k++) tick;
      chk("t4_reach3", int'(cnt), 3);
      bus.abort = 1;
      tick;
      bus.abort = 0;
      chk("t4_busy", int'(bus.busy), 0);
      record(4);
      chk("t4_frozen", rv[3], 3);
      chk("t4_no_done", first_done(4), -1);
      go(10, 0, 1, 1);
      chk("t4_clear", int'(bus.counter_rst), 1);
      tick;
      chk("t4_restart_cnt", int'(cnt), 0);
      wait_idle;
      go(6, 1, 2, 1);
      repeat (10) tick;
      chk("t5_in_down", int'({bus.busy, bus.counter_dir}), 2);
      bus.start = 1;
      bus.peak = 2;
      bus.floor = 0;
      tick;
      bus.start = 0;
      record(7);
      chk("t5_done_at", first_done(7), 5);
      chk("t5_floor", rv[5], 1);
      go(4, 0, 5, 1);
      repeat (7) tick;
      chk("t6_dwell", int'({bus.busy, bus.counter_en, bus.counter_dir}), 5);
      #2 rst = 1;
      #1 chk("t6_async_outs", int'({bus.counter_rst, bus.counter_en, bus.counter_dir, bus.busy, bus.done, bus.err}), 0);
      tick;
      rst = 0;
      tick;
      chk("t6_cnt_held", int'(cnt), 4);
      for (int r = 0; r < 30; r++) begin
         go($urandom_range(0, 20), $urandom_range(0, 24), $urandom_range(0, 4), $urandom_range(0, 4));
         for (int k = 0; k < 600 && bus.busy; k++) begin
            bus.abort = $urandom_range(0, 59) == 0;
            bus.start = $urandom_range(0, 9) == 0;
            bus.peak = 8'($urandom_range(0, 20));
            bus.floor = 8'($urandom_range(0, 24));
            bus.dwell = 8'($urandom_range(0, 4));
            bus.cycles = 4'($urandom_range(0, 4));
            tick;
         end
         bus.abort = 0;
         bus.start = 0;
         wait_idle;
         repeat ($urandom_range(0, 3)) tick;
      end
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

Controller that sequences the 8-bit up/down counter through a programmed triangular ramp profile. It drives the counter's `rst`, `enable` and `direction` inputs and reads back the counter value. On `start` it clears the counter, ramps up to `peak`, dwells, then ramps down to `floor`, repeating for a programmed number of periods. It sits between the configuration/control logic and the counter instance.

## Interface
- `WIDTH`, 8: counter value width; must match the counter.
- `DWELL_W`, 8: dwell field width.
- `CYC_W`, 4: period-count field width.

- `clk`: in, 1. Single clock; all state updates on posedge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `start`: in, 1. Begin a profile. Sampled only in IDLE.
- `abort`: in, 1. Synchronous stop; highest priority after `rst`.
- `peak`: in, WIDTH. Upper turning value.
- `floor`: in, WIDTH. Lower turning value.
- `dwell`: in, DWELL_W. Hold length at each turning point.
- `cycles`: in, CYC_W. Number of up/down periods; 0 is treated as 1.
- `counter_in`: in, WIDTH. Current counter output.
- `counter_rst`: out, 1. Drives counter `rst`.
- `counter_en`: out, 1. Drives counter `enable`.
- `counter_dir`: out, 1. Drives counter `direction`; 1 = up.
- `busy`: out, 1. High in every state except IDLE.
- `done`: out, 1. One-cycle pulse at profile completion.
- `err`: out, 1. One-cycle pulse, coincident with `done`, when `floor > peak`.

## Operation
- `peak`, `floor`, `dwell` and `cycles` are latched on the edge that accepts `start`. Later input changes have no effect until the next start.
- States and transitions:
  - IDLE → CLEAR on `start`.
  - CLEAR → UP. If latched `floor > peak`, CLEAR → DONE with `err` set instead.
  - UP → DWELL_HI when `counter_in == peak`.
  - DWELL_HI → DOWN after its dwell time.
  - DOWN → DWELL_LO when `counter_in == floor` and periods remain.
  - DOWN → DONE when `counter_in == floor` on the last period.
  - DWELL_LO → UP after its dwell time.
  - DONE → IDLE unconditionally.
- Outputs per state:
  - `counter_rst` = 1 only in CLEAR.
  - `counter_en` = (UP and `counter_in != peak`) or (DOWN and `counter_in != floor`). This is combinational, so the counter never overshoots.
  - `counter_dir` = 1 in CLEAR, UP and DWELL_HI; 0 otherwise.
- Dwell states last max(`dwell`, 1) cycles, with `counter_en` = 0 throughout.
- The period counter decrements on each DOWN exit. The first period starts at 0; later periods start at `floor`.
- `abort` in any non-IDLE state → IDLE next edge. No `done` pulse; `counter_en` is 0 from that edge on.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE. `counter_rst`, `counter_en`, `counter_dir`, `busy`, `done` and `err` are all 0.
- `start` accepted at edge k → CLEAR for cycle k..k+1 → counter reads 0 and UP begins after edge k+1.
- UP occupies `peak`+1 cycles: `peak` enabled cycles plus one terminal cycle. With `peak` = 0 it occupies 1 cycle.
- DOWN occupies (`peak` − `floor`)+1 cycles.
- `done` is asserted for exactly the one cycle spent in DONE; `busy` is 1 in that cycle and drops on the following edge.
- Counter wrap-around is never exercised, because enable gating guarantees values stay within [0, `peak`].
- `rst` mid-profile → IDLE immediately; outputs go to their reset values asynchronously.

## Structure
- Package `ramp_seq_pkg`: state enumeration (IDLE, CLEAR, UP, DWELL_HI, DOWN, DWELL_LO, DONE) and the default width constants.
- Sub-module `dwell_timer`:
  - Loadable down-counter of width DWELL_W.
  - Inputs: `load`, `value`.
  - Output: `expire`, asserted in the last dwell cycle.
  - Instantiated once; reloaded on entry to either dwell state.
- Top level: state register, latched configuration, period counter, output decode.
- Bench: closed loop with a real counter instance.

## Test plan
- `peak`=5, `floor`=2, `dwell`=3, `cycles`=1 → counter reads 0,1,2,3,4,5, holds 5 for 4 cycles (UP terminal cycle + 3 dwell), then 4,3,2. `done` pulses on the cycle after counter first reads 2; total 15 cycles from start acceptance to `done`.
- `peak`=3, `floor`=1, `dwell`=0, `cycles`=2 → 0..3, down to 1, 1-cycle hold, up to 3, down to 1, `done`. The counter never exceeds 3 or goes below 1 after the first UP.
- `floor`=7, `peak`=4 → `done` and `err` pulse together 2 cycles after start; `counter_en` stays 0 throughout.
- `abort` asserted while counter=3 in UP → `busy` low next edge, counter frozen at 3, no `done`. A new `start` restarts from CLEAR (counter back to 0).
- `start` pulsed during DOWN and `peak` changed mid-run → no effect on the running profile. Async `rst` mid-DWELL_HI → all outputs 0 immediately, state IDLE.
